coax_tx_framer: RTL and testbench
=================================

// Module: coax_tx_framer
// PURPOSE
//   Transmit framer directly downstream of coax_bit_timer: consumes its strobe/first_half/second_half
//   and serialises 10-bit words into a biphase (Manchester) coax frame on tx.
//   Frame = line quiesce, code violation, one or more words (sync bit + data MSB first + parity),
//   then the ending sequence. Fed by the host-side word interface through a valid/ready handshake.
// PARAMETERS
//   QUIESCE_BITS  5  number of line-quiesce '1' bit cells at frame start (>=1)
//   WORD_BITS     10 data bits per word
//   DELAY_CLOCKS  2  tx_delay lag in clk cycles (used only with COAX_TX_DELAY_EN, >=1)
// PORTS
//   clk            in   1          system clock
//   reset          in   1          synchronous, active-high reset
//   bit_strobe     in   1          1-cycle pulse at start of each bit cell (coax_bit_timer.strobe)
//   bit_first_half in   1          high during first half of cell (coax_bit_timer.first_half)
//   bit_second_half in  1          high during second half of cell (coax_bit_timer.second_half)
//   data           in   WORD_BITS  word to transmit
//   valid          in   1          data valid
//   ready          out  1          holding register empty; transfer when valid && ready
//   tx             out  1          line output, registered
//   tx_delay       out  1          delayed copy of tx (see CONFIGURATION)
//   active         out  1          high for the whole frame
// BEHAVIOUR
//   - Reset: holding empty, state IDLE, tx=0, tx_delay=0, active=0, ready=1; a word presented
//     with reset high is discarded. Reset mid-frame aborts immediately; no ending sequence is sent.
//   - Holding register: one word; ready = !full. Load on valid&&ready; cleared when its word is
//     started. Load and start in the same cycle is impossible (start requires full).
//   - Cell encoding (h0 = first-half level, h1 = second-half level): data bit v -> (~v, v);
//     quiesce cell (0,1); code violation = 3 cells (1,1),(1,0),(0,0); ending = (1,0),(1,1).
//   - tx <= bit_first_half ? h0 : (bit_second_half ? h1 : tx); 1-clk latency vs timer inputs.
//   - All state advances occur only on bit_strobe cycles; the new cell's h0/h1 take effect on that
//     same strobe cycle (registered into tx on the following edge).
//   - States: IDLE -> QUIESCE (QUIESCE_BITS cells) -> CV (3 cells) -> SYNC (1 cell, v=1)
//     -> DATA (WORD_BITS cells, MSB first) -> PARITY (1 cell) -> SYNC if holding full at the
//     strobe ending PARITY, else END (2 cells) -> IDLE.
//   - IDLE exits only on a bit_strobe with holding full; word is moved to shift register at SYNC entry.
//   - Parity: even over data+parity bit (parity = ^data).
//   - active: set on the strobe leaving IDLE, cleared on the strobe ending the last END cell.
//   - Underrun: empty holding at PARITY end terminates the frame normally; later words start a new frame.
//   - tx=0 in IDLE; no output change while bit_strobe/halves are static (timer held in reset).
// CONFIGURATION
//   COAX_TX_DELAY_EN defined: tx_delay = tx delayed by DELAY_CLOCKS clk cycles (shift reg, reset 0),
//     driving the external line driver's pre-emphasis input.
//   COAX_TX_DELAY_EN undefined: tx_delay tied to 0, no delay logic synthesised.
// TESTING (coax_bit_timer CLOCKS_PER_BIT=8 wired in, QUIESCE_BITS=5)
//   - Single word 10'h2A5 -> 22 cells: 01x5, CV 11/10/00, sync 01, data MSB first, parity 1 (01),
//     end 10/11; active high exactly 176 clks; ready re-asserts one clk after SYNC entry.
//   - Two words 10'h000, 10'h3FF loaded back-to-back -> one frame of 34 cells, parity 0 for both,
//     no quiesce/CV between words; tx transitions at every half-cell boundary in data region.
//   - Second word presented 1 clk after first word's PARITY ends -> first frame ends (END cells),
//     second word sent in new frame with full quiesce+CV.
//   - Reset asserted mid-DATA for 1 clk -> tx=0, active=0, ready=1 next cycle; no END cells;
//     a word loaded afterwards produces a complete, correct frame.
//   - valid held high with reset high -> no load; ready=1, active stays 0.
//   - With COAX_TX_DELAY_EN, DELAY_CLOCKS=2 -> tx_delay equals tx two clks earlier throughout;
//     without it tx_delay constant 0.

Source files
------------

// File: rtl/coax_tx_framer.sv
// Biphase coax transmit framer: quiesce, code violation, words (sync+data+parity), ending sequence.
// Optional tx_delay pre-emphasis tap enabled by defining COAX_TX_DELAY_EN.
module coax_tx_framer #(
  parameter int unsigned QUIESCE_BITS = 5,
  parameter int unsigned WORD_BITS    = 10,
  parameter int unsigned DELAY_CLOCKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_strobe,
  input  logic                 bit_first_half,
  input  logic                 bit_second_half,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 tx_delay,
  output logic                 active
);

  localparam int unsigned CNT_MAX = (QUIESCE_BITS > WORD_BITS) ? QUIESCE_BITS : WORD_BITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    CV,
    SYNC,
    DATA,
    PARITY,
    ENDSEQ
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_BITS-1:0] hold;
  logic                 full;
  logic [WORD_BITS-1:0] shreg;
  logic                 par;
  logic                 cur_h0;
  logic                 cur_h1;

  state_t               nstate;
  logic [CNT_W-1:0]     ncnt;
  logic                 nh0;
  logic                 nh1;
  logic                 take;
  logic                 shift;
  logic                 eff_h0;
  logic                 eff_h1;

  assign ready = !full;

  // Next-cell decode; only consumed on bit_strobe cycles.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nh0    = cur_h0;
    nh1    = cur_h1;
    take   = 1'b0;
    shift  = 1'b0;
    case (state)
      IDLE: begin
        if (full) begin
          nstate = QUIESCE;
          ncnt   = '0;
          nh0    = 1'b0;
          nh1    = 1'b1;
        end else begin
          nh0 = 1'b0;
          nh1 = 1'b0;
        end
      end
      QUIESCE: begin
        if (cnt == CNT_W'(QUIESCE_BITS - 1)) begin
          nstate = CV;
          ncnt   = '0;
          nh0    = 1'b1;
          nh1    = 1'b1;
        end else begin
          ncnt = cnt + 1'b1;
          nh0  = 1'b0;
          nh1  = 1'b1;
        end
      end
      CV: begin
        if (cnt == CNT_W'(0)) begin
          ncnt = CNT_W'(1);
          nh0  = 1'b1;
          nh1  = 1'b0;
        end else if (cnt == CNT_W'(1)) begin
          ncnt = CNT_W'(2);
          nh0  = 1'b0;
          nh1  = 1'b0;
        end else begin
          nstate = SYNC;
          ncnt   = '0;
          nh0    = 1'b0;
          nh1    = 1'b1;
          take   = 1'b1;
        end
      end
      SYNC: begin
        nstate = DATA;
        ncnt   = '0;
        nh0    = ~shreg[WORD_BITS-1];
        nh1    = shreg[WORD_BITS-1];
      end
      DATA: begin
        if (cnt == CNT_W'(WORD_BITS - 1)) begin
          nstate = PARITY;
          ncnt   = '0;
          nh0    = ~par;
          nh1    = par;
        end else begin
          ncnt  = cnt + 1'b1;
          nh0   = ~shreg[WORD_BITS-2];
          nh1   = shreg[WORD_BITS-2];
          shift = 1'b1;
        end
      end
      PARITY: begin
        if (full) begin
          nstate = SYNC;
          ncnt   = '0;
          nh0    = 1'b0;
          nh1    = 1'b1;
          take   = 1'b1;
        end else begin
          nstate = ENDSEQ;
          ncnt   = '0;
          nh0    = 1'b1;
          nh1    = 1'b0;
        end
      end
      ENDSEQ: begin
        if (cnt == CNT_W'(0)) begin
          ncnt = CNT_W'(1);
          nh0  = 1'b1;
          nh1  = 1'b1;
        end else begin
          nstate = IDLE;
          ncnt   = '0;
          nh0    = 1'b0;
          nh1    = 1'b0;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
        nh0    = 1'b0;
        nh1    = 1'b0;
      end
    endcase
  end

  // The new cell's levels apply on the strobe cycle itself, before cur_h0/cur_h1 catch up.
  assign eff_h0 = bit_strobe ? nh0 : cur_h0;
  assign eff_h1 = bit_strobe ? nh1 : cur_h1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hold   <= '0;
      full   <= 1'b0;
      shreg  <= '0;
      par    <= 1'b0;
      cur_h0 <= 1'b0;
      cur_h1 <= 1'b0;
      tx     <= 1'b0;
      active <= 1'b0;
    end else begin
      if (bit_strobe) begin
        state  <= nstate;
        cnt    <= ncnt;
        cur_h0 <= nh0;
        cur_h1 <= nh1;
        active <= (nstate != IDLE);
        if (take) begin
          shreg <= hold;
          par   <= ^hold;
        end else if (shift) begin
          shreg <= {shreg[WORD_BITS-2:0], 1'b0};
        end
      end

      if (bit_strobe && take) begin
        full <= 1'b0;
      end else if (valid && !full) begin
        full <= 1'b1;
        hold <= data;
      end

      if (bit_first_half) begin
        tx <= eff_h0;
      end else if (bit_second_half) begin
        tx <= eff_h1;
      end
    end
  end

`ifdef COAX_TX_DELAY_EN
  logic [DELAY_CLOCKS-1:0] dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly <= '0;
    end else if (DELAY_CLOCKS == 1) begin
      dly[0] <= tx;
    end else begin
      dly <= {dly[DELAY_CLOCKS-2:0], tx};
    end
  end

  assign tx_delay = dly[DELAY_CLOCKS-1];
`else
  logic unused_delay_cfg;

  assign unused_delay_cfg = (DELAY_CLOCKS > 0);
  assign tx_delay         = 1'b0;
`endif

endmodule

// File: tb/tb_coax_tx_framer.sv
// Scoreboard bench for coax_tx_framer with an 8-clock bit timer modelled in the bench.
module tb_coax_tx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [9:0] data;
  logic       ready;
  logic       tx;
  logic       tx_delay;
  logic       active;
  logic [2:0] ph = '0;
  logic       bit_strobe;
  logic       bit_first_half;
  logic       bit_second_half;

  always #5 clk = ~clk;

  always @(posedge clk) ph <= ph + 3'd1;
  assign bit_strobe      = (ph == 3'd0);
  assign bit_first_half  = !ph[2];
  assign bit_second_half = ph[2];

  coax_tx_framer #(
    .QUIESCE_BITS(5),
    .WORD_BITS   (10),
    .DELAY_CLOCKS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bit_strobe     (bit_strobe),
    .bit_first_half (bit_first_half),
    .bit_second_half(bit_second_half),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .tx             (tx),
    .tx_delay       (tx_delay),
    .active         (active)
  );

  int         checks = 0;
  int         passes = 0;
  logic [1:0] exp_q[$];
  int         len_q[$];
  bit         mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push_cell(input logic h0, input logic h1);
    exp_q.push_back({h0, h1});
  endtask

  task automatic push_start();
    for (int i = 0; i < 5; i++) push_cell(1'b0, 1'b1);
    push_cell(1'b1, 1'b1);
    push_cell(1'b1, 1'b0);
    push_cell(1'b0, 1'b0);
  endtask

  task automatic push_word(input logic [9:0] d, input logic p);
    push_cell(1'b0, 1'b1);
    for (int i = 9; i >= 0; i--) push_cell(~d[i], d[i]);
    push_cell(~p, p);
  endtask

  task automatic push_end(input int cells);
    push_cell(1'b1, 1'b0);
    push_cell(1'b1, 1'b1);
    len_q.push_back(cells * 8);
  endtask

  // Monitor: one comparison per frame cell, frame length on active fall, tx_delay per cell.
  initial begin
    logic h0_s = 1'b0;
    logic act_prev = 1'b0;
    logic hist1 = 1'b0;
    logic hist2 = 1'b0;
    int   alen = 0;
    int   quiet = 4;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (ph == 3'd3) h0_s = tx;
      if (ph == 3'd7 && active && mon_en) begin
        if (exp_q.size() == 0) chk("cell_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("cell", int'({h0_s, tx}), int'(e));
        end
      end
      if (active) alen++;
      if (act_prev && !active) begin
        if (mon_en) begin
          if (len_q.size() == 0) chk("active_len_unexpected", alen, 0);
          else chk("active_len", alen, len_q.pop_front());
        end
        alen = 0;
      end
      act_prev = active;
      if (reset) quiet = 4;
      else if (quiet > 0) quiet--;
`ifdef COAX_TX_DELAY_EN
      if (ph == 3'd5 && quiet == 0) chk("tx_delay", tx_delay, hist2);
`else
      if (ph == 3'd5) chk("tx_delay", tx_delay, 0);
`endif
      hist2 = hist1;
      hist1 = tx;
    end
  end

  task automatic send_word(input logic [9:0] d);
    int n;
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 0, 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_active();
    int n = 0;
    while (!active && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("active_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    // Word offered while in reset must be dropped.
    data  = 10'h155;
    valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_active", active, 0);
    chk("rst_tx", tx, 0);
    valid = 1'b0;
    reset = 1'b0;
    repeat (24) @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_active", active, 0);
    chk("post_rst_tx", tx, 0);

    // Single word, parity 1, ready returns 64 clks after frame start.
    push_start();
    push_word(10'h2A5, 1'b1);
    push_end(22);
    send_word(10'h2A5);
    wait_active();
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_latency", n, 64);
    wait_idle();

    // Back-to-back words in one frame.
    push_start();
    push_word(10'h000, 1'b0);
    push_word(10'h3FF, 1'b0);
    push_end(34);
    send_word(10'h000);
    send_word(10'h3FF);
    wait_idle();

    // Second word arrives one clk after PARITY ends: two separate frames.
    push_start();
    push_word(10'h2A5, 1'b1);
    push_end(22);
    push_start();
    push_word(10'h13C, 1'b1);
    push_end(22);
    send_word(10'h2A5);
    wait_active();
    repeat (160) @(negedge clk);
    data  = 10'h13C;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_idle();

    // Reset mid-DATA aborts without END cells.
    mon_en = 1'b0;
    send_word(10'h2A5);
    wait_active();
    repeat (96) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", tx, 0);
    chk("abort_active", active, 0);
    chk("abort_ready", ready, 1);
    repeat (32) @(negedge clk);
    chk("abort_no_end_active", active, 0);
    chk("abort_no_end_tx", tx, 0);
    mon_en = 1'b1;

    push_start();
    push_word(10'h0F0, 1'b0);
    push_end(22);
    send_word(10'h0F0);
    wait_idle();

    chk("cells_left", exp_q.size(), 0);
    chk("frames_left", len_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
